// File: rtl/calc_pkg.sv
// Shared definitions for the binary calculator: ALU opcodes, flag positions,
// FSM state encoding and frame geometry.
package calc_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;
    localparam logic [3:0] OP_EQ   = 4'd11;
    localparam logic [3:0] OP_LT   = 4'd12;
    localparam logic [3:0] OP_INC  = 4'd13;
    localparam logic [3:0] OP_DEC  = 4'd14;
    localparam logic [3:0] OP_ZERO = 4'd15;

    // Bit positions inside FLAGS = {Z,C,V,N}
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_READY = 3'd1,
        S_EXEC  = 3'd2,
        S_WR    = 3'd3,
        S_RD    = 3'd4,
        S_LOAD  = 3'd5,
        S_TX    = 3'd6
    } state_e;

    function automatic int frame_width(input int data_w);
        return 3 * data_w + 8;
    endfunction

endpackage

// File: rtl/calc_if.sv
// Command/result bus of the calculator core; master drives commands, slave is the core.
interface calc_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DIV_W   = 32,
    parameter int BURST_W = 4
);
    logic               INPUT_KEY;
    logic               VALID_CMD;
    logic               MEM_MODE;
    logic               RW_MEM;
    logic [ADDR_W-1:0]  ADDR;
    logic [BURST_W-1:0] BURST;
    logic [DATA_W-1:0]  IN_A;
    logic [DATA_W-1:0]  IN_B;
    logic [3:0]         SEL;
    logic               CONFIG_DIV;
    logic [DIV_W-1:0]   DIN;
    logic               CALC_ACTIVE;
    logic               CALC_MODE;
    logic               BUSY;
    logic               D_OUT_VALID;
    logic               D_OUT;
    logic               CLK_Tx;
    logic               TX_DONE;

    modport master (
        output INPUT_KEY, VALID_CMD, MEM_MODE, RW_MEM, ADDR, BURST, IN_A, IN_B, SEL, CONFIG_DIV, DIN,
        input  CALC_ACTIVE, CALC_MODE, BUSY, D_OUT_VALID, D_OUT, CLK_Tx, TX_DONE
    );

    modport slave (
        input  INPUT_KEY, VALID_CMD, MEM_MODE, RW_MEM, ADDR, BURST, IN_A, IN_B, SEL, CONFIG_DIV, DIN,
        output CALC_ACTIVE, CALC_MODE, BUSY, D_OUT_VALID, D_OUT, CLK_Tx, TX_DONE
    );
endinterface

// File: rtl/calc_alu.sv
// Combinational ALU producing the DATA_W result and {Z,C,V,N} flags.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        sel_i,
    output logic [DATA_W-1:0] res_o,
    output logic [3:0]        flags_o
);
    localparam int M = DATA_W - 1;

    logic [DATA_W:0]   wide_s;
    logic [DATA_W-1:0] res_s;
    logic              carry_s;
    logic              ovf_s;

    // Opcode decode; C doubles as borrow for SUB/DEC and shifted-out bit for SHL/SHR
    always_comb begin
        wide_s  = '0;
        res_s   = '0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (sel_i)
            OP_ADD: begin
                wide_s  = {1'b0, a_i} + {1'b0, b_i};
                res_s   = wide_s[M:0];
                carry_s = wide_s[DATA_W];
                ovf_s   = (a_i[M] == b_i[M]) && (res_s[M] != a_i[M]);
            end
            OP_SUB: begin
                wide_s  = {1'b0, a_i} - {1'b0, b_i};
                res_s   = wide_s[M:0];
                carry_s = wide_s[DATA_W];
                ovf_s   = (a_i[M] != b_i[M]) && (res_s[M] != a_i[M]);
            end
            OP_MUL:  res_s = a_i * b_i;
            OP_AND:  res_s = a_i & b_i;
            OP_OR:   res_s = a_i | b_i;
            OP_XOR:  res_s = a_i ^ b_i;
            OP_NOT:  res_s = ~a_i;
            OP_SHL: begin
                res_s   = {a_i[M-1:0], 1'b0};
                carry_s = a_i[M];
            end
            OP_SHR: begin
                res_s   = {1'b0, a_i[M:1]};
                carry_s = a_i[0];
            end
            OP_ROL:  res_s = {a_i[M-1:0], a_i[M]};
            OP_ROR:  res_s = {a_i[0], a_i[M:1]};
            OP_EQ:   res_s = {{M{1'b0}}, (a_i == b_i)};
            OP_LT:   res_s = {{M{1'b0}}, (a_i < b_i)};
            OP_INC: begin
                wide_s  = {1'b0, a_i} + {{DATA_W{1'b0}}, 1'b1};
                res_s   = wide_s[M:0];
                carry_s = wide_s[DATA_W];
            end
            OP_DEC: begin
                wide_s  = {1'b0, a_i} - {{DATA_W{1'b0}}, 1'b1};
                res_s   = wide_s[M:0];
                carry_s = wide_s[DATA_W];
            end
            OP_ZERO: res_s = '0;
            default: res_s = '0;
        endcase
        flags_o         = 4'b0000;
        flags_o[FLAG_Z] = (res_s == '0);
        flags_o[FLAG_C] = carry_s;
        flags_o[FLAG_V] = ovf_s;
        flags_o[FLAG_N] = res_s[M];
        res_o           = res_s;
    end

endmodule

// File: rtl/calc_serializer.sv
// MSB-first frame shifter with programmable bit period and optional even-parity tail bit.
module calc_serializer #(
    parameter int FRAME_W   = 32,
    parameter int PARITY_EN = 1,
    parameter int DIV_W     = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               load_i,
    input  logic               run_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [DIV_W-1:0]   div_i,
    output logic               bit_o,
    output logic               tick_o,
    output logic               last_o
);
    localparam int LEN  = FRAME_W + PARITY_EN;
    localparam int SR_W = FRAME_W + 1;
    localparam int BC_W = $clog2(LEN + 1);
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [BC_W-1:0]  BC_ONE  = {{(BC_W-1){1'b0}}, 1'b1};
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(LEN - 1);

    function automatic logic even_parity(input logic [FRAME_W-1:0] f);
        return ^f;
    endfunction

    logic [SR_W-1:0]  shift_q, shift_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, period_s;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;

    // Bit-period counting and shift control; a zero divider behaves as one
    always_comb begin
        period_s  = (div_i == '0) ? DIV_ONE : div_i;
        tick_o    = run_i && (div_cnt_q == (period_s - DIV_ONE));
        last_o    = tick_o && (bit_cnt_q == BC_LAST);
        shift_d   = shift_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (load_i) begin
            shift_d   = {frame_i, even_parity(frame_i)};
            div_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (tick_o) begin
            shift_d   = {shift_q[SR_W-2:0], 1'b0};
            div_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + BC_ONE;
        end else if (run_i) begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // Serializer state registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            shift_q   <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_o = shift_q[SR_W-1];

endmodule

// File: rtl/binary_calc_core.sv
// Calculator top: command FSM, operand latches, result-frame RAM, ALU and serial transmitter.
module binary_calc_core
    import calc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DIV_W     = 32,
    parameter int BURST_W   = 4,
    parameter int PARITY_EN = 1
) (
    input  logic   CLK,
    input  logic   RESET,
    calc_if.slave  bus
);
    localparam int FRAME_W = frame_width(DATA_W);
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]   DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [3:0]         sel_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BURST_W-1:0] burst_q;
    logic [DIV_W-1:0]   div_q;
    logic [FRAME_W-1:0] frame_q;
    logic               calc_mode_q;
    logic               tx_done_q;
    logic [FRAME_W-1:0] mem [2**ADDR_W];

    logic               cmd_accept_s, cfg_ok_s, calc_active_s, busy_s, d_out_valid_s;
    logic [DATA_W-1:0]  alu_a_s, alu_b_s, alu_res_s;
    logic [3:0]         alu_sel_s, alu_flags_s;
    logic [FRAME_W-1:0] alu_frame_s;
    logic               ser_bit_s, ser_tick_s, ser_last_s;

    assign alu_a_s     = calc_active_s ? a_q   : '0;
    assign alu_b_s     = calc_active_s ? b_q   : '0;
    assign alu_sel_s   = calc_active_s ? sel_q : 4'd0;
    assign alu_frame_s = {alu_a_s, alu_b_s, alu_res_s, alu_sel_s, alu_flags_s};

    calc_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i     (alu_a_s),
        .b_i     (alu_b_s),
        .sel_i   (alu_sel_s),
        .res_o   (alu_res_s),
        .flags_o (alu_flags_s)
    );

    calc_serializer #(.FRAME_W(FRAME_W), .PARITY_EN(PARITY_EN), .DIV_W(DIV_W)) u_ser (
        .CLK     (CLK),
        .RESET   (RESET),
        .load_i  (state_q == S_LOAD),
        .run_i   (state_q == S_TX),
        .frame_i (frame_q),
        .div_i   (div_q),
        .bit_o   (ser_bit_s),
        .tick_o  (ser_tick_s),
        .last_o  (ser_last_s)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; INPUT_KEY in READY takes priority over a simultaneous command
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF:   state_d = bus.INPUT_KEY ? S_READY : S_OFF;
            S_READY: begin
                if (bus.INPUT_KEY) begin
                    state_d = S_OFF;
                end else if (cmd_accept_s) begin
                    state_d = !bus.MEM_MODE ? S_EXEC : (bus.RW_MEM ? S_WR : S_RD);
                end else begin
                    state_d = S_READY;
                end
            end
            S_EXEC:  state_d = S_LOAD;
            S_WR:    state_d = S_READY;
            S_RD:    state_d = S_LOAD;
            S_LOAD:  state_d = S_TX;
            S_TX: begin
                if (ser_last_s) begin
                    state_d = (burst_q != '0) ? S_RD : S_READY;
                end else begin
                    state_d = S_TX;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // FSM output decode
    always_comb begin
        busy_s        = 1'b0;
        d_out_valid_s = 1'b0;
        cfg_ok_s      = 1'b0;
        case (state_q)
            S_OFF, S_READY:             cfg_ok_s = 1'b1;
            S_EXEC, S_WR, S_RD, S_LOAD: busy_s   = 1'b1;
            S_TX: begin
                busy_s        = 1'b1;
                d_out_valid_s = 1'b1;
            end
            default:                    busy_s   = 1'b0;
        endcase
        calc_active_s = (state_q != S_OFF);
        cmd_accept_s  = (state_q == S_READY) && bus.VALID_CMD && !bus.INPUT_KEY;
    end

    // Command capture, frame buffer, burst walk and divider configuration
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= 4'd0;
            addr_q      <= '0;
            burst_q     <= '0;
            div_q       <= DIV_ONE;
            frame_q     <= '0;
            calc_mode_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            if (cmd_accept_s) begin
                a_q         <= bus.IN_A;
                b_q         <= bus.IN_B;
                sel_q       <= bus.SEL;
                addr_q      <= bus.ADDR;
                burst_q     <= (bus.MEM_MODE && !bus.RW_MEM) ? bus.BURST : '0;
                calc_mode_q <= bus.MEM_MODE;
            end
            if (state_q == S_EXEC) begin
                frame_q <= alu_frame_s;
            end
            if (state_q == S_RD) begin
                frame_q <= mem[addr_q];
            end
            // Address increments modulo 2**ADDR_W, so a burst wraps past the top
            if ((state_q == S_TX) && ser_last_s && (burst_q != '0)) begin
                addr_q  <= addr_q + ADDR_ONE;
                burst_q <= burst_q - BURST_ONE;
            end
            if (bus.CONFIG_DIV && cfg_ok_s) begin
                div_q <= bus.DIN;
            end
            tx_done_q <= (state_q == S_TX) && ser_last_s && (burst_q == '0);
        end
    end

    // Result-frame RAM, contents survive reset
    always_ff @(posedge CLK) begin
        if (RESET && (state_q == S_WR)) begin
            mem[addr_q] <= alu_frame_s;
        end
    end

    assign bus.CALC_ACTIVE = calc_active_s;
    assign bus.CALC_MODE   = calc_mode_q;
    assign bus.BUSY        = busy_s;
    assign bus.D_OUT_VALID = d_out_valid_s;
    assign bus.D_OUT       = d_out_valid_s & ser_bit_s;
    assign bus.CLK_Tx      = ser_tick_s;
    assign bus.TX_DONE     = tx_done_q;

endmodule

// File: tb/tb_binary_calc_core.sv
// Directed bench for binary_calc_core: ALU vector table plus hand-written memory,
// burst-wrap, divider and reset sequences, decoded from the serial output.
module tb_binary_calc_core;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int DIV_W     = 32;
    localparam int BURST_W   = 4;
    localparam int PARITY_EN = 1;
    localparam int LEN       = 3 * DATA_W + 8 + PARITY_EN;
    localparam int NVEC      = 20;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] res;
        logic [3:0] flags;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    calc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

    binary_calc_core #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W), .BURST_W(BURST_W), .PARITY_EN(PARITY_EN)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_key();
        bus.INPUT_KEY = 1'b1;
        @(negedge clk);
        bus.INPUT_KEY = 1'b0;
    endtask

    task automatic config_div(input logic [DIV_W-1:0] din);
        bus.CONFIG_DIV = 1'b1;
        bus.DIN        = din;
        @(negedge clk);
        bus.CONFIG_DIV = 1'b0;
    endtask

    // Returns at the negedge following the accepting edge; operands are scrambled afterwards
    task automatic send_cmd(input logic mm, input logic rw, input logic [7:0] addr, input logic [3:0] burst,
                            input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        bus.MEM_MODE  = mm;
        bus.RW_MEM    = rw;
        bus.ADDR      = addr;
        bus.BURST     = burst;
        bus.IN_A      = a;
        bus.IN_B      = b;
        bus.SEL       = sel;
        bus.VALID_CMD = 1'b1;
        @(negedge clk);
        bus.VALID_CMD = 1'b0;
        bus.IN_A      = 8'h5A;
        bus.IN_B      = 8'hC3;
        bus.SEL       = 4'd2;
        bus.ADDR      = 8'h77;
        bus.BURST     = 4'd9;
    endtask

    // Collects one frame; poke_bit >= 0 pulses key, command and divider load during that bit
    task automatic rx_frame(input int p, input int poke_bit, output logic [LEN-1:0] bits,
                            output int lat, output int errs);
        lat  = 0;
        errs = 0;
        bits = '0;
        while (bus.D_OUT_VALID !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < LEN; i++) begin
            for (int j = 0; j < p; j++) begin
                if (poke_bit >= 0) begin
                    if (i == poke_bit && j == 0) begin
                        bus.VALID_CMD  = 1'b1;
                        bus.INPUT_KEY  = 1'b1;
                        bus.CONFIG_DIV = 1'b1;
                        bus.DIN        = 32'd7;
                        bus.IN_A       = 8'hEE;
                    end else begin
                        bus.VALID_CMD  = 1'b0;
                        bus.INPUT_KEY  = 1'b0;
                        bus.CONFIG_DIV = 1'b0;
                    end
                end
                if (bus.D_OUT_VALID !== 1'b1) errs++;
                if (j == 0) bits[LEN-1-i] = bus.D_OUT;
                else if (bus.D_OUT !== bits[LEN-1-i]) errs++;
                if (bus.CLK_Tx !== (j == p - 1)) errs++;
                @(negedge clk);
            end
        end
        bus.VALID_CMD  = 1'b0;
        bus.INPUT_KEY  = 1'b0;
        bus.CONFIG_DIV = 1'b0;
    endtask

    task automatic expect_frame(input string name, input int p, input int poke_bit,
                                input logic [31:0] f, input int exp_lat);
        logic [LEN-1:0] bits;
        int lat, errs;
        rx_frame(p, poke_bit, bits, lat, errs);
        check({name, " latency"}, lat, exp_lat);
        check({name, " frame"}, bits, {f, ^f});
        check({name, " bit timing"}, errs, 0);
    endtask

    initial begin
        bus.INPUT_KEY  = 1'b0;
        bus.VALID_CMD  = 1'b0;
        bus.MEM_MODE   = 1'b0;
        bus.RW_MEM     = 1'b0;
        bus.ADDR       = 8'h00;
        bus.BURST      = 4'd0;
        bus.IN_A       = 8'h00;
        bus.IN_B       = 8'h00;
        bus.SEL        = 4'd0;
        bus.CONFIG_DIV = 1'b0;
        bus.DIN        = 32'd0;

        vecs[0]  = '{8'h05, 8'h03, 4'h0, 8'h08, 4'h0};
        vecs[1]  = '{8'h03, 8'h05, 4'h1, 8'hFE, 4'h5};
        vecs[2]  = '{8'h80, 8'h00, 4'h7, 8'h00, 4'hC};
        vecs[3]  = '{8'h7F, 8'h01, 4'h0, 8'h80, 4'h3};
        vecs[4]  = '{8'hFF, 8'h01, 4'h0, 8'h00, 4'hC};
        vecs[5]  = '{8'h80, 8'h01, 4'h1, 8'h7F, 4'h2};
        vecs[6]  = '{8'h10, 8'h11, 4'h2, 8'h10, 4'h0};
        vecs[7]  = '{8'hF0, 8'h3C, 4'h3, 8'h30, 4'h0};
        vecs[8]  = '{8'hF0, 8'h0F, 4'h4, 8'hFF, 4'h1};
        vecs[9]  = '{8'hAA, 8'hAA, 4'h5, 8'h00, 4'h8};
        vecs[10] = '{8'h0F, 8'h00, 4'h6, 8'hF0, 4'h1};
        vecs[11] = '{8'h81, 8'h00, 4'h8, 8'h40, 4'h4};
        vecs[12] = '{8'h81, 8'h00, 4'h9, 8'h03, 4'h0};
        vecs[13] = '{8'h81, 8'h00, 4'hA, 8'hC0, 4'h1};
        vecs[14] = '{8'h42, 8'h42, 4'hB, 8'h01, 4'h0};
        vecs[15] = '{8'h03, 8'h04, 4'hC, 8'h01, 4'h0};
        vecs[16] = '{8'h04, 8'h03, 4'hC, 8'h00, 4'h8};
        vecs[17] = '{8'hFF, 8'h00, 4'hD, 8'h00, 4'hC};
        vecs[18] = '{8'h00, 8'h00, 4'hE, 8'hFF, 4'h5};
        vecs[19] = '{8'h12, 8'h34, 4'hF, 8'h00, 4'h8};

        repeat (3) @(negedge clk);
        check("reset outputs", {bus.CALC_ACTIVE, bus.CALC_MODE, bus.BUSY, bus.D_OUT_VALID,
                                bus.D_OUT, bus.CLK_Tx, bus.TX_DONE}, 7'b0000000);
        rst = 1'b1;
        @(negedge clk);

        send_cmd(1'b0, 1'b0, 8'h00, 4'd0, 8'h05, 8'h03, 4'h0);
        check("command in OFF ignored", {bus.BUSY, bus.CALC_ACTIVE}, 2'b00);
        pulse_key();
        check("key turns on", bus.CALC_ACTIVE, 1'b1);
        config_div(32'd4);

        send_cmd(1'b0, 1'b0, 8'h00, 4'd0, 8'h05, 8'h03, 4'h0);
        expect_frame("add 05+03", 4, -1, 32'h05030800, 2);
        check("add tx_done", {bus.TX_DONE, bus.BUSY}, 2'b10);
        @(negedge clk);
        check("add after done", {bus.TX_DONE, bus.BUSY, bus.CALC_ACTIVE, bus.CALC_MODE}, 4'b0010);

        send_cmd(1'b0, 1'b0, 8'h00, 4'd0, 8'h03, 8'h05, 4'h1);
        expect_frame("sub pokes mid-tx", 4, 10, 32'h0305FE15, 2);
        check("pokes ignored", {bus.TX_DONE, bus.CALC_ACTIVE}, 2'b11);

        send_cmd(1'b1, 1'b1, 8'hFF, 4'd0, 8'h7F, 8'h01, 4'h0);
        check("write busy", {bus.BUSY, bus.D_OUT_VALID}, 2'b10);
        @(negedge clk);
        check("write no transmit", {bus.BUSY, bus.D_OUT_VALID, bus.TX_DONE, bus.CALC_MODE}, 4'b0001);
        send_cmd(1'b1, 1'b1, 8'h00, 4'd0, 8'h01, 8'h01, 4'h0);
        @(negedge clk);
        send_cmd(1'b1, 1'b0, 8'hFF, 4'd1, 8'h00, 8'h00, 4'h0);
        expect_frame("burst ff", 4, -1, 32'h7F018003, 2);
        check("burst mid", {bus.TX_DONE, bus.BUSY}, 2'b01);
        expect_frame("burst wrap 00", 4, -1, 32'h01010200, 2);
        check("burst done", {bus.TX_DONE, bus.CALC_MODE}, 2'b11);
        @(negedge clk);

        send_cmd(1'b0, 1'b0, 8'h00, 4'd0, 8'hAA, 8'h55, 4'h5);
        repeat (8) @(negedge clk);
        check("transmitting before reset", bus.D_OUT_VALID, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("reset mid-tx", {bus.D_OUT, bus.D_OUT_VALID, bus.BUSY, bus.CALC_ACTIVE, bus.CLK_Tx}, 5'b00000);
        rst = 1'b1;
        @(negedge clk);

        pulse_key();
        send_cmd(1'b1, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00, 4'h0);
        expect_frame("ram kept div reset", 1, -1, 32'h01010200, 2);
        @(negedge clk);

        config_div(32'd0);
        send_cmd(1'b0, 1'b0, 8'h00, 4'd0, 8'h80, 8'h00, 4'h7);
        expect_frame("shl div0 pokes", 1, 5, 32'h8000007C, 2);
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            send_cmd(1'b0, 1'b0, 8'h00, 4'd0, vecs[i].a, vecs[i].b, vecs[i].sel);
            expect_frame($sformatf("vec%0d", i), 1, -1,
                         {vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].sel, vecs[i].flags}, 2);
        end

        bus.INPUT_KEY = 1'b1;
        bus.VALID_CMD = 1'b1;
        bus.MEM_MODE  = 1'b0;
        @(negedge clk);
        bus.INPUT_KEY = 1'b0;
        bus.VALID_CMD = 1'b0;
        check("key beats command", {bus.CALC_ACTIVE, bus.BUSY}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
